// File: rtl/msg_egress_pkg.sv
// Shared types and constants for the message egress serializer.
// Holds the buffered-message entry layout, the read FSM states and the byte-count helper.
package msg_egress_pkg;

  localparam int MSG_IN_BITS   = 256;
  localparam int MSG_IN_BYTES  = MSG_IN_BITS / 8;
  localparam int MSG_OUT_BITS  = 64;
  localparam int MSG_OUT_BYTES = MSG_OUT_BITS / 8;
  localparam int MSG_LEN_W     = $clog2(MSG_IN_BYTES) + 1;

  typedef struct packed {
    logic [MSG_IN_BITS-1:0] data;
    logic [MSG_LEN_W-1:0]   len;
  } msg_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } msg_state_t;

  function automatic logic [MSG_LEN_W-1:0] mask_to_len(input logic [MSG_IN_BYTES-1:0] mask);
    logic [MSG_LEN_W-1:0] n;
    n = '0;
    for (int i = 0; i < MSG_IN_BYTES; i++) begin
      n = n + MSG_LEN_W'(mask[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Generic synchronous FIFO of whole entries; head is visible the cycle after the write.
// Push while full is accepted only together with a pop; pop on empty is ignored.
module msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/msg_egress_serializer.sv
// Buffers parsed 256-bit messages and replays them as framed 64-bit beats; first beat one cycle after capture.
// Egress honours out_ready with stable outputs; ingress has no backpressure, so a full FIFO drops and counts.
module msg_egress_serializer
  import msg_egress_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = MSG_IN_BITS,
  parameter int OUT_DATA_WIDTH = MSG_OUT_BITS,
  parameter int DEPTH          = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   in_valid,
  input  logic [IN_DATA_WIDTH-1:0]               in_data,
  input  logic [IN_DATA_WIDTH/8-1:0]             in_bytemask,
  input  logic                                   clr_stats,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_DATA_WIDTH-1:0]              out_data,
  output logic                                   out_sop,
  output logic                                   out_eop,
  output logic [$clog2(OUT_DATA_WIDTH/8)-1:0]    out_empty,
  output logic [$clog2(DEPTH):0]                 fill_level,
  output logic                                   overflow,
  output logic [CNT_WIDTH-1:0]                   drop_count
);

  localparam int IN_BYTES  = IN_DATA_WIDTH / 8;
  localparam int OUT_BYTES = OUT_DATA_WIDTH / 8;
  localparam int OSEL_W    = $clog2(OUT_BYTES);
  localparam int LEN_W     = $clog2(IN_BYTES) + 1;
  localparam int BEATS     = IN_BYTES / OUT_BYTES;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FILL_W    = $clog2(DEPTH) + 1;
  localparam int BIT_W     = $clog2(IN_DATA_WIDTH);

  msg_state_t                  state;
  msg_state_t                  state_nxt;
  logic [BEAT_W-1:0]           beat_idx;
  msg_entry_t                  wr_entry;
  msg_entry_t                  head;
  logic [$bits(msg_entry_t)-1:0] head_bits;
  logic                        full;
  logic                        empty;
  logic [FILL_W-1:0]           count;
  logic [LEN_W-1:0]            in_len;
  logic [LEN_W-1:0]            len_m1;
  logic [LEN_W-1:0]            neg_len;
  logic [LEN_W-1:0]            byte_pos;
  logic [BIT_W-1:0]            bit_pos;
  logic                        msg_vld;
  logic                        push;
  logic                        pop;
  logic                        drop;
  logic                        xfer;
  logic                        last_beat;

  assign in_len   = mask_to_len(in_bytemask);
  assign msg_vld  = in_valid && (in_len != '0);
  assign wr_entry = '{data: in_data, len: in_len};
  assign head     = msg_entry_t'(head_bits);

  assign len_m1    = head.len - 1'b1;
  assign neg_len   = '0 - head.len;
  assign last_beat = (LEN_W'(beat_idx) == (len_m1 >> OSEL_W));

  assign xfer = out_valid && out_ready;
  assign pop  = xfer && last_beat;
  // A full FIFO still takes the write when the head leaves in the same cycle.
  assign push = msg_vld && (!full || pop);
  assign drop = msg_vld && full && !pop;

  assign fill_level = count;

  msg_fifo #(
    .WIDTH ($bits(msg_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .head    (head_bits)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Entering SEND on the push itself gives the one-cycle capture-to-sop latency.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty || push) state_nxt = SEND;
      SEND:    if (pop && (count == FILL_W'(1)) && !push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  beat_idx <= '0;
    else if (xfer) beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
  end

  always_comb begin
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_empty = '0;
    out_data  = '0;
    byte_pos  = '0;
    bit_pos   = '0;
    if (state == SEND) begin
      out_valid = 1'b1;
      out_sop   = (beat_idx == '0);
      out_eop   = last_beat;
      if (last_beat) out_empty = neg_len[OSEL_W-1:0];
      for (int k = 0; k < OUT_BYTES; k++) begin
        byte_pos = LEN_W'(beat_idx) * LEN_W'(OUT_BYTES) + LEN_W'(k);
        bit_pos  = {byte_pos[LEN_W-2:0], 3'b000};
        if (byte_pos < head.len) out_data[8*(OUT_BYTES-1-k) +: 8] = head.data[bit_pos +: 8];
      end
    end
  end

  // A drop in the same cycle as clr_stats restarts the count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (clr_stats)        drop_count <= CNT_WIDTH'(1);
      else if (!(&drop_count)) drop_count <= drop_count + 1'b1;
    end else if (clr_stats) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule
